// File: rtl/mesi_isc_pkg.sv
// Shared definitions for the MESI intersection controller.
//   mbus_cmd_e   : main-bus command encoding (NOP .. RD_BROAD)
//   CpuCount     : number of CPU main-bus ports
//   CpuIdWidth   : width of a CPU id
//   MbusCmdWidth : width of a main-bus command
//   is_broad_cmd : true for the two broadcast commands the arbiter accepts
package mesi_isc_pkg;

    localparam int unsigned CpuCount     = 4;
    localparam int unsigned CpuIdWidth   = 2;
    localparam int unsigned MbusCmdWidth = 3;

    typedef enum logic [MbusCmdWidth-1:0] {
        MbusCmdNop     = 3'd0,
        MbusCmdWr      = 3'd1,
        MbusCmdRd      = 3'd2,
        MbusCmdWrBroad = 3'd3,
        MbusCmdRdBroad = 3'd4
    } mbus_cmd_e;

    function automatic logic is_broad_cmd(input logic [MbusCmdWidth-1:0] cmd);
        return (cmd == MbusCmdWrBroad) || (cmd == MbusCmdRdBroad);
    endfunction

endpackage

// File: rtl/mesi_isc_breq_arb_fifo.sv
// Single-clock FIFO holding the pending broadcast requests of one CPU.
//   clk, rst : clock, synchronous active-high reset
//   push_i   : write wdata_i (ignored when full)
//   wdata_i  : data to write
//   pop_i    : drop the head entry (ignored when empty)
//   rdata_o  : head entry, valid while empty_o is low
//   full_o   : no free entry
//   empty_o  : no stored entry
module mesi_isc_breq_arb_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 35
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrWidth = $clog2(Depth);
    localparam int unsigned CntWidth = PtrWidth + 1;

    logic [Width-1:0]    mem_q [Depth];
    logic [PtrWidth-1:0] wptr_q, wptr_d;
    logic [PtrWidth-1:0] rptr_q, rptr_d;
    logic [CntWidth-1:0] count_q, count_d;
    logic                do_push;
    logic                do_pop;

    assign full_o  = (count_q == CntWidth'(Depth));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q];

    // Depth is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/mesi_isc_breq_arbiter.sv
// Broadcast-request arbiter: captures WR_BROAD / RD_BROAD from four CPU main-bus ports,
// acknowledges each with a one-cycle pulse, queues them per CPU and presents them one at a
// time in round-robin order over a valid/ready handshake.
//   clk, rst          : clock, synchronous active-high reset
//   mbus_cmd_array_i  : per-CPU command (index = CPU id)
//   mbus_addr_array_i : per-CPU address
//   mbus_ack_o        : per-CPU one-cycle capture acknowledge
//   breq_valid_o      : a request is presented downstream
//   breq_cmd_o        : command of the presented request
//   breq_addr_o       : address of the presented request
//   breq_id_o         : originating CPU id
//   breq_ready_i      : downstream accepts when high together with breq_valid_o
module mesi_isc_breq_arbiter
    import mesi_isc_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [CpuCount-1:0][MbusCmdWidth-1:0] mbus_cmd_array_i,
    input  logic [CpuCount-1:0][ADDR_WIDTH-1:0]   mbus_addr_array_i,
    output logic [CpuCount-1:0]                   mbus_ack_o,
    output logic                                  breq_valid_o,
    output logic [MbusCmdWidth-1:0]               breq_cmd_o,
    output logic [ADDR_WIDTH-1:0]                 breq_addr_o,
    output logic [CpuIdWidth-1:0]                 breq_id_o,
    input  logic                                  breq_ready_i
);

    typedef struct packed {
        logic [MbusCmdWidth-1:0] cmd;
        logic [ADDR_WIDTH-1:0]   addr;
    } breq_t;

    localparam int unsigned ReqWidth = $bits(breq_t);

    logic [CpuCount-1:0]     capture;
    logic [CpuCount-1:0]     q_full;
    logic [CpuCount-1:0]     q_empty;
    logic [CpuCount-1:0]     q_pop;
    breq_t                   q_head [CpuCount];

    logic [CpuCount-1:0]     ack_q;
    logic                    valid_q, valid_d;
    logic [MbusCmdWidth-1:0] cmd_q, cmd_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [CpuIdWidth-1:0]   id_q, id_d;
    logic [CpuIdWidth-1:0]   rr_ptr_q, rr_ptr_d;

    logic                    load_en;
    logic                    sel_found;
    logic [CpuIdWidth-1:0]   sel_id;

    for (genvar i = 0; i < CpuCount; i++) begin : g_cpu
        breq_t wdata;

        // A port is not sampled during its ack cycle: the CPU is still dropping the
        // request that was just captured.
        assign capture[i] = is_broad_cmd(mbus_cmd_array_i[i]) && !q_full[i] && !ack_q[i];
        assign wdata      = '{cmd: mbus_cmd_array_i[i], addr: mbus_addr_array_i[i]};

        mesi_isc_breq_arb_fifo #(
            .Depth (FIFO_DEPTH),
            .Width (ReqWidth)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (capture[i]),
            .wdata_i (wdata),
            .pop_i   (q_pop[i]),
            .rdata_o (q_head[i]),
            .full_o  (q_full[i]),
            .empty_o (q_empty[i])
        );
    end

    // Round-robin search: first non-empty queue starting at rr_ptr.
    always_comb begin
        logic [CpuIdWidth-1:0] cand;
        cand      = '0;
        sel_found = 1'b0;
        sel_id    = '0;
        for (int k = 0; k < CpuCount; k++) begin
            cand = rr_ptr_q + CpuIdWidth'(k);
            if (!sel_found && !q_empty[cand]) begin
                sel_found = 1'b1;
                sel_id    = cand;
            end
        end
    end

    assign load_en = !valid_q || breq_ready_i;
    assign q_pop   = (load_en && sel_found) ? (CpuCount'(1) << sel_id) : '0;

    always_comb begin
        valid_d  = valid_q;
        cmd_d    = cmd_q;
        addr_d   = addr_q;
        id_d     = id_q;
        rr_ptr_d = rr_ptr_q;
        if (load_en) begin
            valid_d = sel_found;
            if (sel_found) begin
                cmd_d    = q_head[sel_id].cmd;
                addr_d   = q_head[sel_id].addr;
                id_d     = sel_id;
                rr_ptr_d = sel_id + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q    <= '0;
            valid_q  <= 1'b0;
            cmd_q    <= '0;
            addr_q   <= '0;
            id_q     <= '0;
            rr_ptr_q <= '0;
        end else begin
            ack_q    <= capture;
            valid_q  <= valid_d;
            cmd_q    <= cmd_d;
            addr_q   <= addr_d;
            id_q     <= id_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign mbus_ack_o   = ack_q;
    assign breq_valid_o = valid_q;
    assign breq_cmd_o   = cmd_q;
    assign breq_addr_o  = addr_q;
    assign breq_id_o    = id_q;

endmodule
